// File: rtl/datapath.sv
// datapath: stage-1 CPU datapath with sixteen general registers, HI/LO, IR, Y,
// 64-bit Z, PC, MDR, 9-bit MAR, a single 32-bit bus, an ALU and a 512-word RAM.
// Driven cycle by cycle by an external sequencer; internal state on view ports.
// Optional feature macro: DATAPATH_ALU_OPS_EN (enables op_sel-selected ALU ops;
// without it the ALU always adds and op_sel is ignored).
module datapath (
    input  logic        clk,
    input  logic        clr,
    input  logic [15:0] R_rd_diog,
    input  logic [15:0] R_wrt_diog,
    input  logic        Rin,
    input  logic        R_out,
    input  logic        BAout,
    input  logic        Gra,
    input  logic        Grb,
    input  logic        Grc,
    input  logic        HI_out,
    input  logic        LO_out,
    input  logic        Zhi_out,
    input  logic        Zlo_out,
    input  logic        PC_out,
    input  logic        MDR_out,
    input  logic        MAR_out,
    input  logic        In_out,
    input  logic        C_out,
    input  logic        MAR_rd,
    input  logic        Zlo_rd,
    input  logic        PC_rd,
    input  logic        MDR_rd,
    input  logic        IR_rd,
    input  logic        Y_rd,
    input  logic        IncPC,
    input  logic        Read,
    input  logic        Write,
    input  logic [4:0]  op_sel,
    output logic [31:0] BusMuxOut,
    output logic [31:0] r3_view,
    output logic [31:0] Y_view,
    output logic [31:0] Zlo_view,
    output logic [31:0] MDR_view,
    output logic [31:0] PC_view,
    output logic [31:0] IR_view,
    output logic [8:0]  MAR_view,
    output logic [31:0] regControl_view
);

    logic [31:0] r [16];
    logic [31:0] hi, lo, ir, y, pc, mdr;
    logic [63:0] z;
    logic [8:0]  mar;
    logic [31:0] ram [512];

    logic [3:0]  reg_idx;
    logic [15:0] dec, reg_ld, reg_drv;
    logic [31:0] c_sext, bus, ram_rd, r0_drive;
    logic [63:0] alu;

    // The array stores the difference from the boot image, so an array that
    // powers up all-zero reads back as the boot image; clr never touches it.
    function automatic logic [31:0] boot_word(input logic [8:0] addr);
        case (addr)
            9'h005:  boot_word = 32'h0000_00B6;
            9'h006:  boot_word = 32'h1180_0034;
            9'h034:  boot_word = 32'h0000_0025;
            default: boot_word = 32'h0000_0000;
        endcase
    endfunction

    // Select-and-encode: IR register field to one-hot, merged with direct enables
    always_comb begin
        reg_idx = ({4{Gra}} & ir[26:23]) | ({4{Grb}} & ir[22:19]) | ({4{Grc}} & ir[18:15]);
        dec     = 16'h0001 << reg_idx;
        reg_ld  = R_rd_diog | ({16{Rin}} & dec);
        reg_drv = R_wrt_diog | ({16{R_out | BAout}} & dec);
        c_sext  = {{13{ir[18]}}, ir[18:0]};
        // Base-address use of R0 means "no base": drive zero unless R0 is driven directly
        r0_drive = (BAout && dec[0] && !R_wrt_diog[0]) ? 32'h0 : r[0];
        ram_rd  = ram[mar] ^ boot_word(mar);
    end

    // Bus mux: later assignments win, so sources are listed lowest priority first
    always_comb begin
        bus = 32'h0;
        if (C_out)   bus = c_sext;
        if (In_out)  bus = 32'h0;
        if (MAR_out) bus = {23'h0, mar};
        if (MDR_out) bus = mdr;
        if (PC_out)  bus = pc;
        if (Zlo_out) bus = z[31:0];
        if (Zhi_out) bus = z[63:32];
        if (LO_out)  bus = lo;
        if (HI_out)  bus = hi;
        for (int i = 15; i >= 1; i--) begin
            if (reg_drv[i]) bus = r[i];
        end
        if (reg_drv[0]) bus = r0_drive;
    end

`ifdef DATAPATH_ALU_OPS_EN
    // ALU: op_sel-selected operation, results widened to 64 bits with sign extension
    always_comb begin
        case (op_sel)
            5'b00100: alu = {{32{y[31]}}, y} - {{32{bus[31]}}, bus};
            5'b00101: alu = {{32{y[31] & bus[31]}}, y & bus};
            5'b00110: alu = {{32{y[31] | bus[31]}}, y | bus};
            5'b01111: alu = {{32{y[31]}}, y} * {{32{bus[31]}}, bus};
            default:  alu = {{32{y[31]}}, y} + {{32{bus[31]}}, bus};
        endcase
    end
`else
    logic op_sel_unused;
    assign op_sel_unused = ^op_sel;

    // ALU: sign-extended 64-bit add of Y and the bus
    always_comb begin
        alu = {{32{y[31]}}, y} + {{32{bus[31]}}, bus};
    end
`endif

    // Register file and special registers; PC_rd takes priority over IncPC
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            for (int i = 0; i < 16; i++) r[i] <= 32'h0;
            hi  <= 32'h0;
            lo  <= 32'h0;
            ir  <= 32'h0;
            y   <= 32'h0;
            z   <= 64'h0;
            pc  <= 32'h0;
            mdr <= 32'h0;
            mar <= 9'h0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (reg_ld[i]) r[i] <= bus;
            end
            if (IR_rd)  ir  <= bus;
            if (Y_rd)   y   <= bus;
            if (Zlo_rd) z   <= alu;
            if (MAR_rd) mar <= bus[8:0];
            if (MDR_rd) mdr <= Read ? ram_rd : bus;
            if (PC_rd)       pc <= bus;
            else if (IncPC)  pc <= pc + 32'd1;
        end
    end

    // RAM write from the pre-edge MDR/MAR; suppressed while clr is asserted
    always_ff @(posedge clk) begin
        if (clr && Write) ram[mar] <= mdr ^ boot_word(mar);
    end

    // View ports
    always_comb begin
        BusMuxOut       = bus;
        r3_view         = r[3];
        Y_view          = y;
        Zlo_view        = z[31:0];
        MDR_view        = mdr;
        PC_view         = pc;
        IR_view         = ir;
        MAR_view        = mar;
        regControl_view = clr ? {reg_drv, reg_ld} : 32'h0;
    end

endmodule

// File: tb/tb_datapath.sv
// tb_datapath: scoreboard bench for datapath. Expected values are queued when
// a control word is driven and compared once the DUT output is due.
module tb_datapath;

    logic        clk, clr;
    logic [15:0] R_rd_diog, R_wrt_diog;
    logic        Rin, R_out, BAout, Gra, Grb, Grc;
    logic        HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out;
    logic        MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd, IncPC, Read, Write;
    logic [4:0]  op_sel;
    logic [31:0] BusMuxOut, r3_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view, regControl_view;
    logic [8:0]  MAR_view;

    datapath dut (
        .clk(clk), .clr(clr),
        .R_rd_diog(R_rd_diog), .R_wrt_diog(R_wrt_diog),
        .Rin(Rin), .R_out(R_out), .BAout(BAout), .Gra(Gra), .Grb(Grb), .Grc(Grc),
        .HI_out(HI_out), .LO_out(LO_out), .Zhi_out(Zhi_out), .Zlo_out(Zlo_out),
        .PC_out(PC_out), .MDR_out(MDR_out), .MAR_out(MAR_out), .In_out(In_out), .C_out(C_out),
        .MAR_rd(MAR_rd), .Zlo_rd(Zlo_rd), .PC_rd(PC_rd), .MDR_rd(MDR_rd), .IR_rd(IR_rd),
        .Y_rd(Y_rd), .IncPC(IncPC), .Read(Read), .Write(Write), .op_sel(op_sel),
        .BusMuxOut(BusMuxOut), .r3_view(r3_view), .Y_view(Y_view), .Zlo_view(Zlo_view),
        .MDR_view(MDR_view), .PC_view(PC_view), .IR_view(IR_view), .MAR_view(MAR_view),
        .regControl_view(regControl_view)
    );

    localparam int O_BUS = 0, O_R3 = 1, O_Y = 2, O_ZLO = 3, O_MDR = 4,
                   O_PC = 5, O_IR = 6, O_MAR = 7, O_RC = 8;

    typedef struct {
        string       tag;
        int          id;
        logic [31:0] exp;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] v_model;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] view(input int id);
        case (id)
            O_BUS:   view = BusMuxOut;
            O_R3:    view = r3_view;
            O_Y:     view = Y_view;
            O_ZLO:   view = Zlo_view;
            O_MDR:   view = MDR_view;
            O_PC:    view = PC_view;
            O_IR:    view = IR_view;
            O_MAR:   view = {23'h0, MAR_view};
            default: view = regControl_view;
        endcase
    endfunction

    task automatic expect_out(input string tag, input int id, input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.id  = id;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.tag, view(e.id), e.exp);
        end
    endtask

    // combinational outputs: let the control word settle, then compare
    task automatic settle();
        #1;
        drain();
    endtask

    // registered outputs: compare just after the capturing edge
    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic clear_ctl();
        R_rd_diog = 16'h0; R_wrt_diog = 16'h0;
        Rin = 0; R_out = 0; BAout = 0; Gra = 0; Grb = 0; Grc = 0;
        HI_out = 0; LO_out = 0; Zhi_out = 0; Zlo_out = 0; PC_out = 0;
        MDR_out = 0; MAR_out = 0; In_out = 0; C_out = 0;
        MAR_rd = 0; Zlo_rd = 0; PC_rd = 0; MDR_rd = 0; IR_rd = 0; Y_rd = 0;
        IncPC = 0; Read = 0; Write = 0;
    endtask

    task automatic expect_all_zero(input string tag);
        for (int i = 0; i <= O_RC; i++) expect_out($sformatf("%s_%0d", tag, i), i, 32'h0);
    endtask

    initial begin
        clear_ctl();
        op_sel = 5'b00011;
        clr = 1'b1;
        #1 clr = 1'b0;
        expect_all_zero("por");
        settle();
        @(posedge clk);
        #1 clr = 1'b1;

        // PC increments, then PC to MAR
        IncPC = 1;
        repeat (5) tick();
        expect_out("pc_inc5", O_PC, 32'd5);
        settle();
        clear_ctl(); PC_out = 1; MAR_rd = 1;
        expect_out("bus_pc5", O_BUS, 32'd5);
        settle();
        expect_out("mar_5", O_MAR, 32'd5);
        tick();

        // memory read and register load
        clear_ctl(); Read = 1; MDR_rd = 1;
        expect_out("mdr_ram5", O_MDR, 32'hB6);
        tick();
        clear_ctl(); MDR_out = 1; R_rd_diog = 16'h0008;
        expect_out("rc_ld3", O_RC, 32'h0000_0008);
        expect_out("bus_mdr", O_BUS, 32'hB6);
        settle();
        expect_out("r3_b6", O_R3, 32'hB6);
        tick();

        // fetch at 6
        clear_ctl(); IncPC = 1;
        tick();
        clear_ctl(); PC_out = 1; MAR_rd = 1; Zlo_rd = 1;
        expect_out("zlo_6", O_ZLO, 32'd6);
        expect_out("mar_6", O_MAR, 32'd6);
        tick();
        clear_ctl(); Zlo_out = 1; PC_rd = 1; Read = 1; MDR_rd = 1;
        expect_out("pc_6", O_PC, 32'd6);
        expect_out("mdr_ram6", O_MDR, 32'h1180_0034);
        tick();
        clear_ctl(); MDR_out = 1; IR_rd = 1;
        expect_out("ir_st", O_IR, 32'h1180_0034);
        expect_out("pc_hold", O_PC, 32'd6);
        tick();

        // store sequence
        clear_ctl(); Grb = 1; BAout = 1; R_out = 1; Y_rd = 1;
        expect_out("rc_rb0", O_RC, 32'h0001_0000);
        expect_out("bus_ba0", O_BUS, 32'h0);
        settle();
        expect_out("y_0", O_Y, 32'h0);
        tick();
        clear_ctl(); C_out = 1; Zlo_rd = 1;
        expect_out("bus_c34", O_BUS, 32'h34);
        settle();
        expect_out("zlo_34", O_ZLO, 32'h34);
        tick();
        clear_ctl(); Zlo_out = 1; MAR_rd = 1;
        expect_out("mar_34", O_MAR, 32'h34);
        tick();
        clear_ctl(); Read = 1; MDR_rd = 1;
        expect_out("mdr_ram34_init", O_MDR, 32'h25);
        tick();
        clear_ctl(); Gra = 1; R_out = 1; MDR_rd = 1;
        expect_out("rc_ra3", O_RC, 32'h0008_0000);
        expect_out("bus_r3", O_BUS, 32'hB6);
        settle();
        expect_out("mdr_r3", O_MDR, 32'hB6);
        tick();
        // write uses the pre-edge MDR while MDR loads 0 on the same edge
        clear_ctl(); Write = 1; In_out = 1; MDR_rd = 1;
        expect_out("mdr_cleared", O_MDR, 32'h0);
        tick();
        clear_ctl(); Read = 1; MDR_rd = 1;
        expect_out("mdr_ram34_wr", O_MDR, 32'hB6);
        tick();

        // bus edge cases
        clear_ctl();
        expect_out("bus_idle", O_BUS, 32'h0);
        settle();
        clear_ctl(); MDR_out = 1; R_rd_diog = 16'h0001;
        tick();
        clear_ctl(); PC_out = 1; R_rd_diog = 16'h0002;
        tick();
        clear_ctl(); R_wrt_diog = 16'h0003;
        expect_out("bus_r0_wins", O_BUS, 32'hB6);
        settle();
        clear_ctl(); Grb = 1; BAout = 1;
        expect_out("bus_ba_r0", O_BUS, 32'h0);
        settle();
        clear_ctl(); Grb = 1; R_out = 1;
        expect_out("bus_rout_r0", O_BUS, 32'hB6);
        settle();
        clear_ctl(); Gra = 1; Rin = 1; PC_out = 1;
        expect_out("rc_rin3", O_RC, 32'h0000_0008);
        settle();
        expect_out("r3_rin", O_R3, 32'd6);
        tick();
        clear_ctl(); MAR_out = 1;
        expect_out("bus_mar", O_BUS, 32'h34);
        settle();

        // PC_rd beats IncPC, then build R2 = 1
        clear_ctl(); In_out = 1; PC_rd = 1; IncPC = 1;
        expect_out("pc_rd_prio", O_PC, 32'h0);
        tick();
        clear_ctl(); IncPC = 1;
        expect_out("pc_1", O_PC, 32'd1);
        tick();
        clear_ctl(); PC_out = 1; R_rd_diog = 16'h0004;
        tick();

        // R4 = 2*R4 + 1 nineteen times through the ALU -> 0x7FFFF
        v_model = 32'h0;
        for (int k = 0; k < 19; k++) begin
            clear_ctl(); R_wrt_diog = 16'h0010; Y_rd = 1;
            tick();
            clear_ctl(); R_wrt_diog = 16'h0010; Zlo_rd = 1;
            expect_out($sformatf("alu_dbl_%0d", k), O_ZLO, v_model << 1);
            tick();
            clear_ctl(); Zlo_out = 1; Y_rd = 1;
            tick();
            v_model = (v_model << 1) | 32'h1;
            clear_ctl(); R_wrt_diog = 16'h0004; Zlo_rd = 1;
            expect_out($sformatf("alu_inc_%0d", k), O_ZLO, v_model);
            tick();
            clear_ctl(); Zlo_out = 1; R_rd_diog = 16'h0010;
            tick();
        end

        // C = 0x7FFFF sign-extends to all ones
        clear_ctl(); Zlo_out = 1; MDR_rd = 1;
        expect_out("mdr_7ffff", O_MDR, 32'h0007_FFFF);
        tick();
        clear_ctl(); MDR_out = 1; IR_rd = 1;
        expect_out("ir_7ffff", O_IR, 32'h0007_FFFF);
        tick();
        clear_ctl(); C_out = 1; Zlo_rd = 1;
        expect_out("bus_c_neg", O_BUS, 32'hFFFF_FFFF);
        settle();
        expect_out("zlo_y_minus1", O_ZLO, 32'h0007_FFFD);
        tick();
        clear_ctl(); In_out = 1; Y_rd = 1;
        tick();
        clear_ctl(); C_out = 1; Zlo_rd = 1;
        expect_out("zlo_neg1", O_ZLO, 32'hFFFF_FFFF);
        tick();
        clear_ctl(); Zhi_out = 1;
        expect_out("bus_zhi_sext", O_BUS, 32'hFFFF_FFFF);
        settle();

        // asynchronous reset mid-run with enables still asserted
        clear_ctl(); MDR_out = 1; R_rd_diog = 16'hFFFF; C_out = 1;
        #2 clr = 1'b0;
        expect_all_zero("rst_mid");
        settle();
        #1 clr = 1'b1;
        clear_ctl(); IncPC = 1;
        expect_out("pc_after_rst", O_PC, 32'd1);
        expect_out("mdr_after_rst", O_MDR, 32'h0);
        tick();

        clear_ctl();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/datapath.md
# datapath

Stage-1 CPU datapath: sixteen 32-bit general registers, special registers (HI, LO, IR, Y, 64-bit Z, PC, MDR, 9-bit MAR), a single 32-bit bus, an adder ALU and a 512-word internal RAM. Select-and-encode logic decodes register fields from IR. The block is driven cycle-by-cycle by an external control sequencer (the bench today, the control unit later). Internal state is exposed on view ports for debug.

## Interface
- No parameters.
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  asynchronous, active-low reset.
- R_rd_diog  in  16  direct per-register load enables; bit i loads Ri from bus.
- R_wrt_diog  in  16  direct per-register bus-drive enables; bit i drives Ri.
- Rin, R_out, BAout  in  1 each  select-and-encode register load, drive, and base-address drive.
- Gra, Grb, Grc  in  1 each  select IR[26:23], IR[22:19], or IR[18:15] as register index.
- HI_out, LO_out, Zhi_out, Zlo_out, PC_out, MDR_out, MAR_out, In_out, C_out  in  1 each  bus-source enables.
- MAR_rd, Zlo_rd, PC_rd, MDR_rd, IR_rd, Y_rd  in  1 each  register load enables.
- IncPC  in  1  PC increment request.
- Read, Write  in  1 each  memory read select and memory write.
- op_sel  in  5  ALU operation; used only with DATAPATH_ALU_OPS_EN.
- BusMuxOut  out  32  current bus value.
- r3_view, Y_view, Zlo_view, MDR_view, PC_view, IR_view  out  32 each  register contents.
- MAR_view  out  9  MAR contents.
- regControl_view  out  32  {final drive enables[15:0], final load enables[15:0]}.

## Operation
- Select and encode:
  - Index = IR field chosen by Gra/Grb/Grc (OR of the selected fields when several are asserted), decoded one-hot to 16 bits.
  - Load enable[i] = R_rd_diog[i] | (Rin & dec[i]).
  - Drive enable[i] = R_wrt_diog[i] | ((R_out | BAout) & dec[i]).
- BAout with R0 selected drives 0. R_out with R0 drives R0's contents.
- C sign extension: C = IR[18:0] sign-extended to 32 bits.
- Bus mux is combinational. Fixed priority: R0…R15, HI, LO, Zhi, Zlo, PC, MDR, MAR (zero-extended), In (constant 0), C. Bus is 0 when no source is enabled.
- ALU is combinational: result = Y + BusMuxOut, 64-bit sign-extended sum. Zlo_rd loads all 64 bits of Z; Zhi holds the sign extension.
- MDR input: RAM[MAR] when Read=1, otherwise BusMuxOut.
- MAR loads BusMuxOut[8:0].
- PC:
  - PC_rd loads the bus and has priority over IncPC.
  - Otherwise IncPC=1 adds 1 per rising edge, wrapping at 2^32.
- RAM:
  - 512 x 32, combinational read at MAR.
  - Synchronous write RAM[MAR] <= MDR when Write=1.
  - Write and a same-edge MDR/MAR load use the pre-edge values.
- RAM initial contents (power-up only, unaffected by clr):
  - [5] = 0x000000B6
  - [6] = 0x11800034 (st 0x34, R3)
  - [0x34] = 0x00000025
  - all other words 0.

## Timing
- Register loads take effect on the rising edge of clk at the end of the cycle in which the enable is high. They are visible on the view ports and the bus one cycle later.
- clr low clears R0–R15, HI, LO, IR, Y, Z, PC, MDR and MAR to 0 immediately, independent of clk.
- While clr is low, all views read 0 and BusMuxOut reads 0 (every source is zero).
- Reset is honored mid-sequence. Loads resume on the first rising edge after clr returns high.
- Simultaneous IncPC and PC_rd: bus value wins.
- RAM write is blocked while clr is low.

## Configuration
- DATAPATH_ALU_OPS_EN defined: Z = f(op_sel), with
  - 00011 add
  - 00100 sub (Y − bus)
  - 00101 AND
  - 00110 OR
  - 01111 signed 32x32 multiply (full 64-bit into Z)
  - any other code: add.
- DATAPATH_ALU_OPS_EN undefined: op_sel is ignored and Z is always Y + bus.

## Test plan
- Reset: clr low mid-run → every view, including MAR_view, and BusMuxOut read 0 immediately.
- PC/MAR: IncPC high for 5 cycles, then PC_out+MAR_rd → PC_view=5, MAR_view=5.
- Memory read and register load:
  - Read+MDR_rd → MDR_view=0xB6.
  - Then MDR_out+R_rd_diog[3] → r3_view=0xB6; regControl_view bit 3 set during that cycle.
- Fetch at 6:
  - IncPC; PC_out+MAR_rd+Zlo_rd → Zlo_view=6.
  - Zlo_out+PC_rd+Read+MDR_rd, then MDR_out+IR_rd → IR_view=0x11800034, PC_view=6.
- Store:
  - Grb+BAout+R_out+Y_rd → Y_view=0.
  - C_out+Zlo_rd → Zlo_view=0x34.
  - Zlo_out+MAR_rd → MAR_view=0x34.
  - Gra+R_out+MDR_rd → MDR_view=0xB6.
  - Write → RAM[0x34]=0xB6, confirmed by Read+MDR_rd readback.
- Bus edge cases:
  - No enables → BusMuxOut=0.
  - IR with C=0x7FFFF and C_out → BusMuxOut=0xFFFFFFFF.
  - R_wrt_diog=0x0003 → R0 wins.
